// File: rtl/fetch_decode_alu_if.sv
// Bus bundle between the enclosing core and the fetch/decode/ALU slice.
// master: the core (drives pc, imem writes and operands); slave: the slice.
interface fetch_decode_alu_if;
    logic [31:0] pc;
    logic        imem_we;
    logic [31:0] imem_waddr;
    logic [31:0] imem_wdata;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] instruction;
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic [25:0] addr;
    logic [31:0] out;
    logic        zero;

    modport master (
        output pc, imem_we, imem_waddr, imem_wdata, a, b,
        input  instruction, opcode, rs, rt, rd, shamt, funct, imm, addr, out, zero
    );

    modport slave (
        input  pc, imem_we, imem_waddr, imem_wdata, a, b,
        output instruction, opcode, rs, rt, rd, shamt, funct, imm, addr, out, zero
    );
endinterface

// File: rtl/fetch_decode_alu.sv
// Fetch -> decode -> ALU registered chain of the MIPS-like core front end.
// Instruction memory is word addressed and read-first on a same-address write.
module fetch_decode_alu #(
    parameter int unsigned IMEM_DEPTH = 1024
) (
    input logic               clk,
    input logic               rst,
    fetch_decode_alu_if.slave bus
);
    localparam int unsigned AW = $clog2(IMEM_DEPTH);

    logic [31:0] imem [IMEM_DEPTH];
    logic [31:0] instr_q;
    logic [31:0] dec_q;   // decode-stage copy of the instruction; fields are slices
    logic [31:0] out_q;
    logic [31:0] alu_d;
    logic        pc_ok;
    logic        we_ok;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [4:0]  sh_var;

    assign pc_ok  = bus.pc < 32'(IMEM_DEPTH);
    assign we_ok  = bus.imem_we && (bus.imem_waddr < 32'(IMEM_DEPTH));
    assign shamt  = dec_q[10:6];
    assign funct  = dec_q[5:0];
    assign sh_var = bus.a[4:0];

    // Instruction memory write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (we_ok) begin
            imem[bus.imem_waddr[AW-1:0]] <= bus.imem_wdata;
        end
    end

    // Fetch, decode and execute registers; out-of-range pc fetches a NOP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_q <= 32'h0;
            dec_q   <= 32'h0;
            out_q   <= 32'h0;
        end else begin
            instr_q <= pc_ok ? imem[bus.pc[AW-1:0]] : 32'h0;
            dec_q   <= instr_q;
            out_q   <= alu_d;
        end
    end

    // R-type ALU function select; undefined funct codes yield zero.
    always_comb begin
        alu_d = 32'h0;
        case (funct)
            6'h00: alu_d = bus.b << shamt;
            6'h02: alu_d = bus.b >> shamt;
            6'h03: alu_d = 32'($signed(bus.b) >>> shamt);
            6'h04: alu_d = bus.b << sh_var;
            6'h06: alu_d = bus.b >> sh_var;
            6'h07: alu_d = 32'($signed(bus.b) >>> sh_var);
            6'h20, 6'h21: alu_d = bus.a + bus.b;
            6'h22, 6'h23: alu_d = bus.a - bus.b;
            6'h24: alu_d = bus.a & bus.b;
            6'h25: alu_d = bus.a | bus.b;
            6'h26: alu_d = bus.a ^ bus.b;
            6'h27: alu_d = ~(bus.a | bus.b);
            6'h2A: alu_d = {31'h0, $signed(bus.a) < $signed(bus.b)};
            6'h2B: alu_d = {31'h0, bus.a < bus.b};
            default: alu_d = 32'h0;
        endcase
    end

    assign bus.instruction = instr_q;
    assign bus.opcode      = dec_q[31:26];
    assign bus.rs          = dec_q[25:21];
    assign bus.rt          = dec_q[20:16];
    assign bus.rd          = dec_q[15:11];
    assign bus.shamt       = dec_q[10:6];
    assign bus.funct       = dec_q[5:0];
    assign bus.imm         = dec_q[15:0];
    assign bus.addr        = dec_q[25:0];
    assign bus.out         = out_q;
    assign bus.zero        = (out_q == 32'h0);
endmodule

// File: tb/tb_fetch_decode_alu.sv
// Directed bench for fetch_decode_alu with hand-computed expectations.
module tb_fetch_decode_alu;
    localparam int unsigned DEPTH = 1024;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fails;

    fetch_decode_alu_if bus ();

    fetch_decode_alu #(
        .IMEM_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic imem_write(input logic [31:0] waddr, input logic [31:0] wdata);
        bus.imem_we    = 1'b1;
        bus.imem_waddr = waddr;
        bus.imem_wdata = wdata;
        tick();
        bus.imem_we    = 1'b0;
    endtask

    // Fetch imem[idx], let it decode, then execute with operands a/b.
    task automatic exec(input string tag, input logic [31:0] idx, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
        bus.pc = idx;
        bus.a  = a;
        bus.b  = b;
        tick();
        tick();
        tick();
        check(tag, bus.out, exp);
        check({tag, "_zero"}, 32'(bus.zero), 32'(exp == 32'h0));
    endtask

    initial begin
        n_checks       = 0;
        n_fails        = 0;
        rst            = 1'b1;
        bus.pc         = 32'(DEPTH);
        bus.imem_we    = 1'b0;
        bus.imem_waddr = 32'h0;
        bus.imem_wdata = 32'h0;
        bus.a          = 32'h0;
        bus.b          = 32'h0;
        tick();
        tick();
        rst = 1'b0;

        check("rst_instr", bus.instruction, 32'h0);
        check("rst_out", bus.out, 32'h0);
        check("rst_zero", 32'(bus.zero), 32'h1);

        imem_write(32'd0,  32'h1234_5678);
        imem_write(32'd5,  32'h0022_1820);
        imem_write(32'd6,  32'h8C43_FFFC);
        imem_write(32'd7,  32'hAAAA_0007);
        imem_write(32'd8,  32'h0800_0010);
        imem_write(32'd10, 32'h0000_0022);  // sub
        imem_write(32'd11, 32'h0000_0103);  // sra shamt=4
        imem_write(32'd12, 32'h0000_0102);  // srl shamt=4
        imem_write(32'd13, 32'h0000_002A);  // slt
        imem_write(32'd14, 32'h0000_002B);  // sltu
        imem_write(32'd15, 32'h0000_003F);  // undefined
        imem_write(32'd16, 32'h0000_0020);  // add
        imem_write(32'd17, 32'h0000_0004);  // sllv
        imem_write(32'd18, 32'h0000_0027);  // nor

        // Fetch and decode of the add at imem[5], then execute a=1, b=2.
        bus.pc = 32'd5;
        bus.a  = 32'd1;
        bus.b  = 32'd2;
        tick();
        check("fetch_instr", bus.instruction, 32'h0022_1820);
        tick();
        check("dec_opcode", 32'(bus.opcode), 32'h0);
        check("dec_rs", 32'(bus.rs), 32'd1);
        check("dec_rt", 32'(bus.rt), 32'd2);
        check("dec_rd", 32'(bus.rd), 32'd3);
        check("dec_shamt", 32'(bus.shamt), 32'd0);
        check("dec_funct", 32'(bus.funct), 32'h20);
        check("dec_imm", 32'(bus.imm), 32'h1820);
        check("dec_addr", 32'(bus.addr), 32'h0221820);
        tick();
        check("add_1_2", bus.out, 32'd3);
        check("add_1_2_zero", 32'(bus.zero), 32'h0);

        exec("sub", 32'd10, 32'd1, 32'd2, 32'hFFFF_FFFF);
        exec("add_wrap", 32'd16, 32'hFFFF_FFFF, 32'd1, 32'h0);
        exec("sra", 32'd11, 32'h0, 32'h8000_0000, 32'hF800_0000);
        exec("srl", 32'd12, 32'h0, 32'h8000_0000, 32'h0800_0000);
        exec("slt", 32'd13, 32'hFFFF_FFFF, 32'd1, 32'd1);
        exec("sltu", 32'd14, 32'hFFFF_FFFF, 32'd1, 32'd0);
        exec("undef", 32'd15, 32'd5, 32'd7, 32'd0);
        exec("sllv", 32'd17, 32'd4, 32'd1, 32'd16);
        exec("nor", 32'd18, 32'h0F0F_0000, 32'h0000_00F0, 32'hF0F0_FF0F);

        // I-type and J-type decode.
        bus.pc = 32'd6;
        tick();
        tick();
        check("i_opcode", 32'(bus.opcode), 32'h23);
        check("i_rs", 32'(bus.rs), 32'd2);
        check("i_rt", 32'(bus.rt), 32'd3);
        check("i_imm", 32'(bus.imm), 32'hFFFC);
        bus.pc = 32'd8;
        tick();
        tick();
        check("j_opcode", 32'(bus.opcode), 32'h02);
        check("j_addr", 32'(bus.addr), 32'h10);

        // Out-of-range pc fetches a NOP.
        bus.pc = 32'd5;
        tick();
        bus.pc = 32'(DEPTH);
        tick();
        check("pc_oob", bus.instruction, 32'h0);

        // Same-cycle write and read of imem[7] is read-first.
        bus.pc = 32'd7;
        tick();
        check("rf_before", bus.instruction, 32'hAAAA_0007);
        imem_write(32'd7, 32'h5555_0007);
        check("rf_old", bus.instruction, 32'hAAAA_0007);
        tick();
        check("rf_new", bus.instruction, 32'h5555_0007);

        // Out-of-range write must not alias onto imem[0].
        bus.pc = 32'(DEPTH);
        imem_write(32'(DEPTH), 32'hDEAD_BEEF);
        bus.pc = 32'd0;
        tick();
        check("waddr_oob", bus.instruction, 32'h1234_5678);

        // Asynchronous reset mid-cycle with a live pipeline.
        bus.pc = 32'd5;
        bus.a  = 32'd1;
        bus.b  = 32'd2;
        tick();
        tick();
        tick();
        check("pre_rst_out", bus.out, 32'd3);
        #2;
        rst = 1'b1;
        #1;
        check("arst_instr", bus.instruction, 32'h0);
        check("arst_rd", 32'(bus.rd), 32'h0);
        check("arst_funct", 32'(bus.funct), 32'h0);
        check("arst_addr", 32'(bus.addr), 32'h0);
        check("arst_out", bus.out, 32'h0);
        check("arst_zero", 32'(bus.zero), 32'h1);
        tick();
        rst = 1'b0;
        tick();
        check("post_rst_fetch", bus.instruction, 32'h0022_1820);
        tick();
        check("post_rst_rd", 32'(bus.rd), 32'd3);
        tick();
        check("post_rst_out", bus.out, 32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule

// File: doc/fetch_decode_alu.md
Name: fetch_decode_alu

Overview:
Front-end/execute slice of the single-cycle-style MIPS-like core. It combines three stages in a 3-stage registered chain:
- Fetch: reads a 32-bit instruction from an internal word-addressed instruction memory at the supplied program counter.
- Decode: splits the instruction into R/I/J fields.
- ALU: computes an R-type result from externally supplied operands using the decoded funct/shamt.

The enclosing core owns the PC, the register file, data RAM and branch logic.

Parameters:
IMEM_DEPTH, 1024, number of 32-bit words in instruction memory (power of two).

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
pc  input  32  word address of instruction to fetch (word-addressed, not byte)
imem_we  input  1  instruction-memory write enable
imem_waddr  input  32  word address for imem write
imem_wdata  input  32  instruction word to write
a  input  32  ALU operand A (rs value)
b  input  32  ALU operand B (rt value)
instruction  output  32  fetched instruction (registered)
opcode  output  6  instruction[31:26] (registered)
rs  output  5  instruction[25:21]
rt  output  5  instruction[20:16]
rd  output  5  instruction[15:11]
shamt  output  5  instruction[10:6]
funct  output  6  instruction[5:0]
imm  output  16  instruction[15:0], raw (no extension)
addr  output  26  instruction[25:0]
out  output  32  ALU result (registered)
zero  output  1  high when out == 0 (combinational from out)

Behaviour:
- Reset (rst=1, asynchronous): instruction, all decoded fields and out clear to 0; zero=1. Instruction memory contents are not reset. Reset is honoured mid-operation; the pipeline restarts cleanly on the first edge after release.
- Fetch, latency 1:
  - On each posedge, instruction <= imem[pc] if pc < IMEM_DEPTH, else 32'h0 (NOP).
  - imem write on posedge when imem_we=1 and imem_waddr < IMEM_DEPTH; out-of-range writes are ignored.
  - Simultaneous read/write of the same address returns the old word (read-first).
- Decode, latency 1 after instruction:
  - On each posedge all fields are loaded from the current instruction register.
  - Fields always decode regardless of format: the enclosing core chooses which fields to use.
- ALU, latency 1 after decode:
  - On each posedge, out <= f(a, b, shamt, funct), using a/b sampled at that edge and the registered shamt/funct.
  - Result is computed every cycle independent of opcode.
  - All arithmetic is 32-bit wrap-around; no overflow trap or flag.
- funct encodings:
  - 0x00 sll: b << shamt
  - 0x02 srl: b >> shamt (logical)
  - 0x03 sra: b >>> shamt (arithmetic)
  - 0x04 sllv: b << a[4:0]
  - 0x06 srlv: logical shift of b by a[4:0]
  - 0x07 srav: arithmetic shift of b by a[4:0]
  - 0x20 add and 0x21 addu: a + b
  - 0x22 sub and 0x23 subu: a − b
  - 0x24 and, 0x25 or, 0x26 xor
  - 0x27 nor: ~(a | b)
  - 0x2A slt: signed a < b → 1 else 0
  - 0x2B sltu: unsigned compare
  - Any other funct: out = 0.
- End-to-end timing: pc presented before edge N gives instruction after N, fields after N+1, and out after N+2, with a/b sampled at edge N+2.

Test Plan:
- Reset and zero flag: assert rst asynchronously mid-cycle -> instruction, fields and out read 0 immediately, zero=1; imem contents preserved after release.
- Load, fetch and decode:
  - Write imem[5]=32'h0022_1820 (add rd=3, rs=1, rt=2) and set pc=5.
  - After 1 edge, instruction=32'h00221820.
  - After 2 edges, opcode=0, rs=1, rt=2, rd=3, shamt=0, funct=0x20, imm=16'h1820, addr=26'h0221820.
- ALU arithmetic: with funct=0x20, a=1, b=2 -> out=3. With funct=0x22, a=1, b=2 -> out=32'hFFFFFFFF, zero=0. With add, a=32'hFFFFFFFF, b=1 -> out=0, zero=1.
- Shifts and compares:
  - sra with shamt=4, b=32'h8000_0000 -> 32'hF800_0000.
  - srl with the same inputs -> 32'h0800_0000.
  - slt with a=32'hFFFFFFFF, b=1 -> 1; sltu with the same inputs -> 0.
  - Undefined funct 0x3F -> 0.
- Boundary fetch:
  - pc=IMEM_DEPTH -> instruction=0.
  - Write imem[7] while pc=7 in the same cycle -> old word on that edge, new word on the next edge.
  - imem_waddr=IMEM_DEPTH is ignored.
- I/J decode: instruction 32'h8C43_FFFC -> opcode=0x23, rs=2, rt=3, imm=16'hFFFC. Instruction 32'h0800_0010 -> opcode=0x02, addr=26'h10.
